// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Shared instruction-class constants, FSM encoding and request
//            record used by the instruction encoder and its packer.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Instruction classes as carried in req_kind and in word bits [27:26]
    localparam logic [1:0] KIND_DP  = 2'b00;
    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_BR  = 2'b10;
    localparam logic [1:0] KIND_ILL = 2'b11;

    // Session FSM encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // One request's worth of instruction fields
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [23:0] imm;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Purpose  : Combinational packer turning request fields into a 32-bit
//            instruction word (DP, memory and branch layouts).
// Revision : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic        [0:0]  i_unused_tie,
    input  req_t               i_req,
    output logic        [31:0] o_word
);

    logic [31:0] w_word;
    logic        w_use_imm;

    // DP takes the immediate when funct[5] (I) is set; memory takes it when
    // funct[5] is clear, since there the bit selects a register offset.
    always_comb begin
        w_word    = '0;
        w_use_imm = 1'b0;
        w_word[31:28] = i_req.cond;
        w_word[27:26] = i_req.kind;
        if (i_req.kind == KIND_BR) begin
            w_word[25]   = 1'b1;
            w_word[24]   = i_req.funct[4];
            w_word[23:0] = i_req.imm;
        end else begin
            w_word[25:20] = i_req.funct;
            w_word[19:16] = i_req.rn;
            w_word[15:12] = i_req.rd;
            w_use_imm = (i_req.kind == KIND_DP) ? i_req.funct[5] : ~i_req.funct[5];
            if (w_use_imm) begin
                w_word[11:0] = i_req.imm[11:0];
            end else begin
                w_word[3:0] = i_req.rm;
            end
        end
    end

    assign o_word = w_word ^ {31'b0, i_unused_tie & 1'b0};

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Session-based instruction encoder. Accepts request fields,
//            packs them into instruction words and writes them to
//            consecutive word addresses of an instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [3:0]  req_cond,
    input  logic [5:0]  req_funct,
    input  logic [3:0]  req_rn,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rm,
    input  logic [23:0] req_imm,
    input  logic        req_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] count,
    output logic        done,
    output logic        err
);

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_last;
    logic [15:0] r_count;
    logic        r_err;

    req_t        w_req;
    logic [31:0] w_word;
    logic        w_hs;
    logic        w_full;

    assign w_req.kind  = req_kind;
    assign w_req.cond  = req_cond;
    assign w_req.funct = req_funct;
    assign w_req.rn    = req_rn;
    assign w_req.rd    = req_rd;
    assign w_req.rm    = req_rm;
    assign w_req.imm   = req_imm;

    instr_pack u_pack (
        .i_unused_tie (1'b0),
        .i_req        (w_req),
        .o_word       (w_word)
    );

    assign w_hs = req_valid && (r_state == c_st_armed);
    // Compared one bit wider so DEPTH = 65536 is reachable
    assign w_full = (({1'b0, r_count} + 17'd1) == 17'(DEPTH));

    // Session FSM with address, word, counter and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state <= c_st_armed;
                        r_addr  <= {base_addr[31:2], 2'b00};
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                c_st_armed: begin
                    if (w_hs) begin
                        if (req_kind == KIND_ILL) begin
                            r_err <= 1'b1;
                            if (req_last) begin
                                r_state <= c_st_done;
                            end
                        end else begin
                            r_wdata <= w_word;
                            r_last  <= req_last;
                            r_state <= c_st_write;
                        end
                    end
                end
                c_st_write: begin
                    r_addr  <= r_addr + 32'd4;
                    r_count <= r_count + 16'd1;
                    if (r_last) begin
                        r_state <= c_st_done;
                    end else if (w_full) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_armed;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // A reset arriving during WRITE suppresses that cycle's strobe too
    assign mem_we    = (r_state == c_st_write) && !reset;
    assign req_ready = (r_state == c_st_armed);
    assign done      = (r_state == c_st_done);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder: directed sessions plus
//            randomized sessions against a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int c_depth = 4;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [23:0] imm;
        bit          last;
    } tb_req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [3:0]  req_cond = '0;
    logic [5:0]  req_funct = '0;
    logic [3:0]  req_rn = '0;
    logic [3:0]  req_rd = '0;
    logic [3:0]  req_rm = '0;
    logic [23:0] req_imm = '0;
    logic        req_last = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] count;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    tb_req_t     q_reqs[$];
    logic [31:0] q_act_addr[$];
    logic [31:0] q_act_data[$];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(c_depth)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_cond  (req_cond),
        .req_funct (req_funct),
        .req_rn    (req_rn),
        .req_rd    (req_rd),
        .req_rm    (req_rm),
        .req_imm   (req_imm),
        .req_last  (req_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    // Record every memory write seen mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            q_act_addr.push_back(mem_addr);
            q_act_data.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Instruction word built arithmetically from the field placement rules
    function automatic logic [31:0] ref_encode(input tb_req_t r);
        int unsigned w;
        int unsigned operand;
        bit          imm_form;
        w = 32'(r.cond) * 32'h1000_0000 + 32'(r.kind) * 32'h0400_0000;
        if (r.kind == 2'd2) begin
            w = w + 32'h0200_0000 + ((32'(r.funct) / 16) % 2) * 32'h0100_0000 + 32'(r.imm);
        end else begin
            imm_form = (r.kind == 2'd0) ? (r.funct >= 6'd32) : (r.funct < 6'd32);
            operand  = imm_form ? (32'(r.imm) % 4096) : 32'(r.rm);
            w = w + 32'(r.funct) * 32'h0010_0000 + 32'(r.rn) * 32'h0001_0000
                  + 32'(r.rd) * 32'h0000_1000 + operand;
        end
        return w;
    endfunction

    function automatic tb_req_t mk(input int kind, input int cond, input int funct,
                                   input int rn, input int rd, input int rm,
                                   input int imm, input bit last);
        tb_req_t r;
        r.kind = 2'(kind); r.cond = 4'(cond); r.funct = 6'(funct);
        r.rn = 4'(rn); r.rd = 4'(rd); r.rm = 4'(rm); r.imm = 24'(imm); r.last = last;
        return r;
    endfunction

    // Runs one session of q_reqs from base and compares against the model
    task automatic run_session(input logic [31:0] base);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        bit          exp_acc[$];
        bit          exp_err;
        bit          closed;
        int          n;
        int          w;
        bit          acc;
        exp_err = 0; closed = 0; n = 0;
        foreach (q_reqs[i]) begin
            exp_acc.push_back(!closed);
            if (!closed) begin
                if (q_reqs[i].kind == 2'd3) begin
                    exp_err = 1;
                    if (q_reqs[i].last) closed = 1;
                end else begin
                    exp_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * n));
                    exp_data.push_back(ref_encode(q_reqs[i]));
                    n++;
                    if (q_reqs[i].last) closed = 1;
                    else if (n == c_depth) begin
                        exp_err = 1;
                        closed  = 1;
                    end
                end
            end
        end

        @(negedge clk);
        q_act_addr.delete();
        q_act_data.delete();
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;

        foreach (q_reqs[i]) begin
            req_kind = q_reqs[i].kind; req_cond = q_reqs[i].cond; req_funct = q_reqs[i].funct;
            req_rn = q_reqs[i].rn; req_rd = q_reqs[i].rd; req_rm = q_reqs[i].rm;
            req_imm = q_reqs[i].imm; req_last = q_reqs[i].last;
            req_valid = 1'b1;
            w = 0;
            while (req_ready !== 1'b1 && w < 8) begin
                @(negedge clk);
                w++;
            end
            acc = (req_ready === 1'b1);
            check_eq("accept", 32'(acc), 32'(exp_acc[i]));
            if (acc) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
                @(negedge clk);
                check_eq("latency_we", 32'(mem_we), 32'(q_reqs[i].kind != 2'd3));
            end else begin
                req_valid = 1'b0;
            end
        end

        w = 0;
        while (done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("done", 32'(done), 32'd1);
        check_eq("nwrites", 32'(q_act_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < q_act_addr.size(); i++) begin
            check_eq("waddr", q_act_addr[i], exp_addr[i]);
            check_eq("wdata", q_act_data[i], exp_data[i]);
        end
        check_eq("count", {16'b0, count}, 32'(n));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("ready_after", 32'(req_ready), 32'd0);
        check_eq("we_after", 32'(mem_we), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_we"},    32'(mem_we),    32'd0);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_done"},  32'(done),      32'd0);
        check_eq({tag, "_err"},   32'(err),       32'd0);
        check_eq({tag, "_count"}, {16'b0, count}, 32'd0);
        check_eq({tag, "_addr"},  mem_addr,       32'd0);
        check_eq({tag, "_wdata"}, mem_wdata,      32'd0);
    endtask

    initial begin
        int n;
        int w;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Single DP immediate word
        q_reqs.delete();
        q_reqs.push_back(mk(0, 14, 6'b101000, 2, 1, 0, 12'h0FF, 1));
        run_session(32'h100);
        if (q_act_data.size() > 0) check_eq("single_word", q_act_data[0], 32'hE28210FF);

        // DP register form, LDR immediate, branch
        q_reqs.delete();
        q_reqs.push_back(mk(0, 14, 6'b001000, 2, 1, 3, 0, 0));
        q_reqs.push_back(mk(1, 14, 6'b011001, 2, 1, 0, 12'h004, 0));
        q_reqs.push_back(mk(2, 14, 6'b100000, 0, 0, 0, 24'hFFFFFE, 1));
        run_session(32'h100);
        if (q_act_data.size() == 3) begin
            check_eq("dp_reg_word", q_act_data[0], 32'hE0821003);
            check_eq("ldr_word",    q_act_data[1], 32'hE5921004);
            check_eq("branch_word", q_act_data[2], 32'hEAFFFFFE);
        end

        // Illegal request mid-session
        q_reqs.delete();
        q_reqs.push_back(mk(0, 1, 6'b100001, 3, 4, 5, 12'h123, 0));
        q_reqs.push_back(mk(3, 2, 6'b000000, 1, 1, 1, 0, 0));
        q_reqs.push_back(mk(1, 3, 6'b110000, 6, 7, 8, 12'hABC, 1));
        run_session(32'h2001);

        // Overflow at DEPTH with no last, fifth request refused
        q_reqs.delete();
        for (int i = 0; i < 5; i++) q_reqs.push_back(mk(0, i, 6'b100000, i, i, i, i, 0));
        run_session(32'h40);

        // Address wrap
        q_reqs.delete();
        q_reqs.push_back(mk(1, 0, 6'b000000, 1, 2, 3, 12'h010, 0));
        q_reqs.push_back(mk(0, 0, 6'b000000, 1, 2, 3, 0, 1));
        run_session(32'hFFFF_FFFE);

        // Reset during WRITE discards the pending write
        @(negedge clk);
        q_act_addr.delete();
        q_act_data.delete();
        start = 1'b1; base_addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        req_kind = 2'd0; req_funct = 6'b100000; req_imm = 24'h77; req_last = 1'b1;
        req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        check_eq("rst_armed", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check_eq("rst_we_gated", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_write");
        check_eq("rst_nowrite", 32'(q_act_addr.size()), 32'd0);

        // Reset dominates start and req_valid
        reset = 1'b1; start = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_dom_ready", 32'(req_ready), 32'd0);

        // Randomized sessions
        for (int s = 0; s < 25; s++) begin
            q_reqs.delete();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                tb_req_t r;
                r.kind  = 2'($urandom_range(0, 3));
                r.cond  = 4'($urandom);
                r.funct = 6'($urandom);
                r.rn    = 4'($urandom);
                r.rd    = 4'($urandom);
                r.rm    = 4'($urandom);
                r.imm   = 24'($urandom);
                r.last  = (i == n - 1) || ($urandom_range(0, 9) == 0);
                q_reqs.push_back(r);
            end
            run_session($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
